// File: rtl/conv_layer_mem_responder_if.sv
`default_nettype none
// ============================================================================
// Module   : conv_layer_mem_responder_if
// Purpose  : Host/engine bus bundle for the convolution-layer memory responder
// Revision : 1.0 - initial release
// ============================================================================
interface conv_layer_mem_responder_if #(
  parameter int DATA_WIDTH = 20,
  parameter int ADDR_WIDTH = 12
);
  logic                  ld_en;
  logic [ADDR_WIDTH-1:0] ld_addr;
  logic [DATA_WIDTH-1:0] ld_data;
  logic                  start;
  logic                  ready;
  logic                  busy;
  logic [ADDR_WIDTH-1:0] iaddr;
  logic [DATA_WIDTH-1:0] idata;
  logic                  cwr;
  logic [ADDR_WIDTH-1:0] caddr_wr;
  logic [DATA_WIDTH-1:0] cdata_wr;
  logic                  crd;
  logic [ADDR_WIDTH-1:0] caddr_rd;
  logic [DATA_WIDTH-1:0] cdata_rd;
  logic [2:0]            csel;
  logic                  dump_en;
  logic                  dump_sel;
  logic [ADDR_WIDTH-1:0] dump_addr;
  logic [DATA_WIDTH-1:0] dump_data;
  logic                  dump_valid;
  logic                  done;
  logic                  err;
  logic [12:0]           l0_wr_cnt;
  logic [10:0]           l1_wr_cnt;

  modport master (
    output ld_en, ld_addr, ld_data, start, busy, iaddr,
           cwr, caddr_wr, cdata_wr, crd, caddr_rd, csel,
           dump_en, dump_sel, dump_addr,
    input  ready, idata, cdata_rd, dump_data, dump_valid,
           done, err, l0_wr_cnt, l1_wr_cnt
  );

  modport slave (
    input  ld_en, ld_addr, ld_data, start, busy, iaddr,
           cwr, caddr_wr, cdata_wr, crd, caddr_rd, csel,
           dump_en, dump_sel, dump_addr,
    output ready, idata, cdata_rd, dump_data, dump_valid,
           done, err, l0_wr_cnt, l1_wr_cnt
  );
endinterface
`default_nettype wire

// File: rtl/conv_layer_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : conv_layer_mem_responder
// Purpose  : Image ROM, L0/L1 layer memories, start handshake and dump port
//            serving the convolution engine
// Revision : 1.0 - initial release
// ============================================================================
module conv_layer_mem_responder #(
  parameter int DATA_WIDTH = 20,
  parameter int ADDR_WIDTH = 12,
  parameter int IMG_DEPTH  = 4096,
  parameter int L1_DEPTH   = 1024
) (
  input  logic                         clk,
  input  logic                         reset,
  conv_layer_mem_responder_if.slave    bus
);

  localparam int                  c_L1_AW    = $clog2(L1_DEPTH);
  localparam logic [ADDR_WIDTH:0] c_L1_LIMIT = (ADDR_WIDTH+1)'(L1_DEPTH);

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    ARM  = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [DATA_WIDTH-1:0] r_img [IMG_DEPTH];
  logic [DATA_WIDTH-1:0] r_l0  [IMG_DEPTH];
  logic [DATA_WIDTH-1:0] r_l1  [L1_DEPTH];

  logic                  r_ready;
  logic                  r_done;
  logic                  r_err;
  logic [DATA_WIDTH-1:0] r_idata;
  logic [DATA_WIDTH-1:0] r_cdata_rd;
  logic [DATA_WIDTH-1:0] r_dump_data;
  logic                  r_dump_valid;
  logic [12:0]           r_l0_wr_cnt;
  logic [10:0]           r_l1_wr_cnt;

  logic w_in_run;
  logic w_csel_l0;
  logic w_csel_l1;
  logic w_wr_l1_ok;
  logic w_rd_l1_ok;
  logic w_dump_l1_ok;
  logic w_img_we;
  logic w_l0_we;
  logic w_l1_we;
  logic w_wr_err;
  logic w_rd_err;
  logic w_clear;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= LOAD;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      LOAD:    if (bus.start) w_next = ARM;
      ARM:     if (bus.busy)  w_next = RUN;
      RUN:     if (!bus.busy) w_next = DONE;
      DONE:    if (bus.start) w_next = LOAD;
      default: w_next = LOAD;
    endcase
  end

  assign w_in_run     = (r_state == RUN);
  assign w_csel_l0    = (bus.csel == 3'b001);
  assign w_csel_l1    = (bus.csel == 3'b011);
  assign w_wr_l1_ok   = ({1'b0, bus.caddr_wr}  < c_L1_LIMIT);
  assign w_rd_l1_ok   = ({1'b0, bus.caddr_rd}  < c_L1_LIMIT);
  assign w_dump_l1_ok = ({1'b0, bus.dump_addr} < c_L1_LIMIT);

  assign w_img_we = bus.ld_en && (r_state == LOAD);
  assign w_l0_we  = bus.cwr && w_in_run && w_csel_l0;
  assign w_l1_we  = bus.cwr && w_in_run && w_csel_l1 && w_wr_l1_ok;

  // Any strobe that is not a legal in-RUN access counts as a protocol error.
  assign w_wr_err = bus.cwr && !(w_in_run && (w_csel_l0 || (w_csel_l1 && w_wr_l1_ok)));
  assign w_rd_err = bus.crd && !(w_in_run && (w_csel_l0 || (w_csel_l1 && w_rd_l1_ok)));
  assign w_clear  = (r_state == DONE) && bus.start;

  // Memory arrays carry no reset; nonblocking reads elsewhere see old data.
  always_ff @(posedge clk) begin
    if (w_img_we) r_img[bus.ld_addr] <= bus.ld_data;
    if (w_l0_we)  r_l0[bus.caddr_wr] <= bus.cdata_wr;
    if (w_l1_we)  r_l1[bus.caddr_wr[c_L1_AW-1:0]] <= bus.cdata_wr;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_idata      <= '0;
      r_cdata_rd   <= '0;
      r_dump_data  <= '0;
      r_dump_valid <= 1'b0;
    end else begin
      r_idata <= r_img[bus.iaddr];
      if (bus.crd && w_in_run) begin
        if (w_csel_l0)                    r_cdata_rd <= r_l0[bus.caddr_rd];
        else if (w_csel_l1 && w_rd_l1_ok) r_cdata_rd <= r_l1[bus.caddr_rd[c_L1_AW-1:0]];
        else                              r_cdata_rd <= '0;
      end
      r_dump_valid <= bus.dump_en;
      if (bus.dump_en) begin
        if (!bus.dump_sel)    r_dump_data <= r_l0[bus.dump_addr];
        else if (w_dump_l1_ok) r_dump_data <= r_l1[bus.dump_addr[c_L1_AW-1:0]];
        else                  r_dump_data <= '0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ready     <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_l0_wr_cnt <= '0;
      r_l1_wr_cnt <= '0;
    end else begin
      r_ready <= (w_next == ARM);
      r_done  <= (w_next == DONE);
      // A fresh error in the clearing cycle still latches.
      r_err   <= (r_err && !w_clear) || w_wr_err || w_rd_err;
      if (w_clear) begin
        r_l0_wr_cnt <= '0;
        r_l1_wr_cnt <= '0;
      end else begin
        if (w_l0_we && !(&r_l0_wr_cnt)) r_l0_wr_cnt <= r_l0_wr_cnt + 13'd1;
        if (w_l1_we && !(&r_l1_wr_cnt)) r_l1_wr_cnt <= r_l1_wr_cnt + 11'd1;
      end
    end
  end

  assign bus.ready      = r_ready;
  assign bus.done       = r_done;
  assign bus.err        = r_err;
  assign bus.idata      = r_idata;
  assign bus.cdata_rd   = r_cdata_rd;
  assign bus.dump_data  = r_dump_data;
  assign bus.dump_valid = r_dump_valid;
  assign bus.l0_wr_cnt  = r_l0_wr_cnt;
  assign bus.l1_wr_cnt  = r_l1_wr_cnt;

endmodule
`default_nettype wire

// File: tb/tb_conv_layer_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_conv_layer_mem_responder
// Purpose  : Directed self-checking bench for conv_layer_mem_responder
// Revision : 1.0 - initial release
// ============================================================================
module tb_conv_layer_mem_responder;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  conv_layer_mem_responder_if #(.DATA_WIDTH(20), .ADDR_WIDTH(12)) bus ();

  conv_layer_mem_responder #(
    .DATA_WIDTH(20), .ADDR_WIDTH(12), .IMG_DEPTH(4096), .L1_DEPTH(1024)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.ld_en = 0; bus.ld_addr = '0; bus.ld_data = '0; bus.start = 0; bus.busy = 0;
    bus.iaddr = '0; bus.cwr = 0; bus.caddr_wr = '0; bus.cdata_wr = '0; bus.crd = 0;
    bus.caddr_rd = '0; bus.csel = 3'b001; bus.dump_en = 0; bus.dump_sel = 0; bus.dump_addr = '0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle();
    repeat (3) tick();
    total++; if (bus.ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b want=0", bus.ready); end
    total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", bus.done); end
    total++; if (bus.err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b want=0", bus.err); end
    total++; if (bus.idata !== 20'h0) begin bad++; $display("FAIL reset_idata got=%h want=0", bus.idata); end
    total++; if (bus.cdata_rd !== 20'h0 || bus.dump_data !== 20'h0 || bus.dump_valid !== 1'b0)
      begin bad++; $display("FAIL reset_data got=%h/%h/%b want=0/0/0", bus.cdata_rd, bus.dump_data, bus.dump_valid); end
    total++; if (bus.l0_wr_cnt !== 13'd0 || bus.l1_wr_cnt !== 11'd0)
      begin bad++; $display("FAIL reset_cnt got=%0d/%0d want=0/0", bus.l0_wr_cnt, bus.l1_wr_cnt); end
    reset = 1'b0;
  endtask

  task automatic test_preload();
    for (int k = 0; k < 4096; k++) begin
      bus.ld_en = 1; bus.ld_addr = 12'(k); bus.ld_data = 20'(k); bus.start = (k == 4095);
      tick();
      if (k == 0) begin
        total++; if (bus.ready !== 1'b0) begin bad++; $display("FAIL load_ready got=%b want=0", bus.ready); end
      end
    end
    total++; if (bus.ready !== 1'b1) begin bad++; $display("FAIL arm_ready got=%b want=1", bus.ready); end
    // ld_en in ARM must not reach the ROM
    bus.start = 0; bus.ld_addr = 12'h007; bus.ld_data = 20'hFFFFF;
    tick();
    bus.ld_en = 0;
    tick();
    total++; if (bus.ready !== 1'b1) begin bad++; $display("FAIL arm_hold_ready got=%b want=1", bus.ready); end
  endtask

  task automatic test_run_entry();
    bus.busy = 1; bus.iaddr = 12'h0A5;
    tick();
    total++; if (bus.ready !== 1'b0) begin bad++; $display("FAIL run_ready got=%b want=0", bus.ready); end
    total++; if (bus.idata !== 20'h000A5) begin bad++; $display("FAIL idata_a5 got=%h want=000a5", bus.idata); end
    bus.iaddr = 12'h007;
    tick();
    total++; if (bus.idata !== 20'h00007) begin bad++; $display("FAIL idata_ignored_ld got=%h want=00007", bus.idata); end
  endtask

  task automatic test_l0_access();
    bus.cwr = 1; bus.csel = 3'b001; bus.caddr_wr = 12'h123; bus.cdata_wr = 20'h0ABCD;
    tick();
    bus.cwr = 0; bus.crd = 1; bus.caddr_rd = 12'h123;
    tick();
    bus.crd = 0;
    total++; if (bus.cdata_rd !== 20'h0ABCD) begin bad++; $display("FAIL l0_read got=%h want=0abcd", bus.cdata_rd); end
    total++; if (bus.l0_wr_cnt !== 13'd1) begin bad++; $display("FAIL l0_cnt got=%0d want=1", bus.l0_wr_cnt); end
    total++; if (bus.err !== 1'b0) begin bad++; $display("FAIL l0_err got=%b want=0", bus.err); end
    bus.caddr_rd = 12'h000;
    tick();
    total++; if (bus.cdata_rd !== 20'h0ABCD) begin bad++; $display("FAIL cdata_hold got=%h want=0abcd", bus.cdata_rd); end
  endtask

  task automatic test_l1_access();
    bus.cwr = 1; bus.csel = 3'b011; bus.caddr_wr = 12'h3FF; bus.cdata_wr = 20'h12345;
    tick();
    total++; if (bus.l1_wr_cnt !== 11'd1) begin bad++; $display("FAIL l1_cnt got=%0d want=1", bus.l1_wr_cnt); end
    total++; if (bus.err !== 1'b0) begin bad++; $display("FAIL l1_err_legal got=%b want=0", bus.err); end
    bus.cwr = 0; bus.crd = 1; bus.caddr_rd = 12'h3FF;
    tick();
    total++; if (bus.cdata_rd !== 20'h12345) begin bad++; $display("FAIL l1_read got=%h want=12345", bus.cdata_rd); end
    bus.crd = 0; bus.cwr = 1; bus.caddr_wr = 12'h400; bus.cdata_wr = 20'h55555;
    tick();
    bus.cwr = 0;
    total++; if (bus.err !== 1'b1) begin bad++; $display("FAIL l1_oob_err got=%b want=1", bus.err); end
    total++; if (bus.l1_wr_cnt !== 11'd1) begin bad++; $display("FAIL l1_oob_cnt got=%0d want=1", bus.l1_wr_cnt); end
    bus.crd = 1; bus.caddr_rd = 12'h400;
    tick();
    bus.crd = 0;
    total++; if (bus.cdata_rd !== 20'h0) begin bad++; $display("FAIL l1_oob_read got=%h want=0", bus.cdata_rd); end
  endtask

  task automatic test_read_before_write();
    bus.cwr = 1; bus.csel = 3'b001; bus.caddr_wr = 12'h005; bus.cdata_wr = 20'h00111;
    tick();
    bus.cdata_wr = 20'h00222; bus.crd = 1; bus.caddr_rd = 12'h005;
    tick();
    bus.cwr = 0;
    total++; if (bus.cdata_rd !== 20'h00111) begin bad++; $display("FAIL rbw_old got=%h want=00111", bus.cdata_rd); end
    tick();
    bus.crd = 0;
    total++; if (bus.cdata_rd !== 20'h00222) begin bad++; $display("FAIL rbw_new got=%h want=00222", bus.cdata_rd); end
    total++; if (bus.l0_wr_cnt !== 13'd3) begin bad++; $display("FAIL rbw_cnt got=%0d want=3", bus.l0_wr_cnt); end
  endtask

  task automatic test_done_dump();
    bus.busy = 0;
    tick();
    total++; if (bus.done !== 1'b1) begin bad++; $display("FAIL done_set got=%b want=1", bus.done); end
    bus.dump_en = 1; bus.dump_sel = 0; bus.dump_addr = 12'h123;
    tick();
    total++; if (bus.dump_data !== 20'h0ABCD || bus.dump_valid !== 1'b1)
      begin bad++; $display("FAIL dump_l0 got=%h/%b want=0abcd/1", bus.dump_data, bus.dump_valid); end
    bus.dump_sel = 1; bus.dump_addr = 12'h3FF;
    tick();
    bus.dump_en = 0;
    total++; if (bus.dump_data !== 20'h12345) begin bad++; $display("FAIL dump_l1 got=%h want=12345", bus.dump_data); end
    tick();
    total++; if (bus.dump_valid !== 1'b0 || bus.dump_data !== 20'h12345)
      begin bad++; $display("FAIL dump_idle got=%h/%b want=12345/0", bus.dump_data, bus.dump_valid); end
  endtask

  task automatic test_rearm();
    bus.start = 1;
    tick();
    bus.start = 0;
    total++; if (bus.done !== 1'b0 || bus.err !== 1'b0 || bus.ready !== 1'b0)
      begin bad++; $display("FAIL rearm_flags got=%b/%b/%b want=0/0/0", bus.done, bus.err, bus.ready); end
    total++; if (bus.l0_wr_cnt !== 13'd0 || bus.l1_wr_cnt !== 11'd0)
      begin bad++; $display("FAIL rearm_cnt got=%0d/%0d want=0/0", bus.l0_wr_cnt, bus.l1_wr_cnt); end
    bus.dump_en = 1; bus.dump_sel = 1; bus.dump_addr = 12'h400;
    tick();
    total++; if (bus.dump_data !== 20'h0 || bus.err !== 1'b0 || bus.dump_valid !== 1'b1)
      begin bad++; $display("FAIL dump_l1_oob got=%h/%b/%b want=0/0/1", bus.dump_data, bus.err, bus.dump_valid); end
    bus.dump_sel = 0; bus.dump_addr = 12'h005;
    tick();
    bus.dump_en = 0;
    total++; if (bus.dump_data !== 20'h00222) begin bad++; $display("FAIL retained got=%h want=00222", bus.dump_data); end
  endtask

  task automatic test_illegal_load();
    bus.cwr = 1; bus.csel = 3'b001; bus.caddr_wr = 12'h123; bus.cdata_wr = 20'h77777;
    tick();
    bus.cwr = 0;
    total++; if (bus.err !== 1'b1 || bus.l0_wr_cnt !== 13'd0)
      begin bad++; $display("FAIL cwr_load got=%b/%0d want=1/0", bus.err, bus.l0_wr_cnt); end
    bus.dump_en = 1; bus.dump_addr = 12'h123;
    tick();
    bus.dump_en = 0;
    total++; if (bus.dump_data !== 20'h0ABCD) begin bad++; $display("FAIL cwr_load_mem got=%h want=0abcd", bus.dump_data); end
  endtask

  task automatic test_reset_mid_run();
    bus.start = 1;
    tick();
    bus.start = 0; bus.busy = 1;
    tick();
    bus.cwr = 1; bus.csel = 3'b001; bus.caddr_wr = 12'h123; bus.cdata_wr = 20'h0ABCD;
    bus.crd = 1; bus.caddr_rd = 12'h123; bus.dump_en = 1; bus.dump_addr = 12'h123;
    tick();
    reset = 1'b1;
    #1;
    total++; if (bus.l0_wr_cnt !== 13'd0 || bus.err !== 1'b0 || bus.ready !== 1'b0 || bus.done !== 1'b0)
      begin bad++; $display("FAIL midrun_flags got=%0d/%b/%b/%b want=0/0/0/0", bus.l0_wr_cnt, bus.err, bus.ready, bus.done); end
    total++; if (bus.cdata_rd !== 20'h0 || bus.dump_data !== 20'h0 || bus.dump_valid !== 1'b0 || bus.idata !== 20'h0)
      begin bad++; $display("FAIL midrun_data got=%h/%h/%b/%h want=0/0/0/0", bus.cdata_rd, bus.dump_data, bus.dump_valid, bus.idata); end
    idle();
    repeat (2) tick();
    reset = 1'b0;
  endtask

  task automatic test_saturation_and_csel();
    bus.start = 1;
    tick();
    bus.start = 0; bus.busy = 1;
    tick();
    bus.cwr = 1; bus.csel = 3'b011;
    for (int i = 0; i < 2050; i++) begin
      bus.caddr_wr = 12'(i % 1024); bus.cdata_wr = 20'(i);
      tick();
    end
    bus.cwr = 0;
    total++; if (bus.l1_wr_cnt !== 11'd2047 || bus.err !== 1'b0)
      begin bad++; $display("FAIL l1_sat got=%0d/%b want=2047/0", bus.l1_wr_cnt, bus.err); end
    bus.cwr = 1; bus.crd = 1; bus.csel = 3'b010; bus.caddr_wr = 12'h123; bus.caddr_rd = 12'h123;
    bus.cdata_wr = 20'h99999;
    tick();
    bus.cwr = 0; bus.crd = 0;
    total++; if (bus.err !== 1'b1 || bus.l0_wr_cnt !== 13'd0 || bus.cdata_rd !== 20'h0)
      begin bad++; $display("FAIL bad_csel got=%b/%0d/%h want=1/0/0", bus.err, bus.l0_wr_cnt, bus.cdata_rd); end
    bus.busy = 0; bus.dump_en = 1; bus.dump_sel = 0; bus.dump_addr = 12'h123;
    tick();
    bus.dump_sel = 1; bus.dump_addr = 12'h005;
    total++; if (bus.dump_data !== 20'h0ABCD) begin bad++; $display("FAIL bad_csel_mem got=%h want=0abcd", bus.dump_data); end
    tick();
    bus.dump_en = 0;
    total++; if (bus.dump_data !== 20'h00405) begin bad++; $display("FAIL l1_last_wr got=%h want=00405", bus.dump_data); end
    total++; if (bus.done !== 1'b1) begin bad++; $display("FAIL final_done got=%b want=1", bus.done); end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_preload();
    test_run_entry();
    test_l0_access();
    test_l1_access();
    test_read_before_write();
    test_done_dump();
    test_rearm();
    test_illegal_load();
    test_reset_mid_run();
    test_saturation_and_csel();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
